// File: rtl/if_line_responder.sv
// if_line_responder: memory-side responder for instruction line fills.
// Accepts a fetch line request, arbitrates for the shared byte-wide RAM port,
// streams LINE_BYTES consecutive bytes into a line buffer and pulses if_done.
// A ROB rollback aborts any fill in flight.
//
// Optional feature: define IF_FILL_STAT_EN to add the fill/abort statistics
// counters (stat_fills, stat_aborts).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   rdy             global enable; low freezes every register
//   if_en, if_pc    line request and address (offset bits ignored)
//   if_done         one-cycle line-complete pulse
//   if_data         assembled line, byte k at [8k+7:8k]
//   rollback        ROB flush; aborts the current fill
//   bus_req/bus_gnt RAM port arbitration handshake
//   mem_a, mem_wr   RAM byte address, write strobe (always 0)
//   mem_din         RAM read data, one enabled cycle after its address
//   stat_fills/stat_aborts  (IF_FILL_STAT_EN only) event counters
module if_line_responder #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    if_en,
  input  logic [ADDR_W-1:0]       if_pc,
  output logic                    if_done,
  output logic [LINE_BYTES*8-1:0] if_data,
  input  logic                    rollback,
  output logic                    bus_req,
  input  logic                    bus_gnt,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic [7:0]              mem_din
`ifdef IF_FILL_STAT_EN
  ,
  output logic [31:0]             stat_fills,
  output logic [31:0]             stat_aborts
`endif
);

  localparam int unsigned IDX_W  = $clog2(LINE_BYTES);
  localparam int unsigned DATA_W = LINE_BYTES * 8;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GNT = 2'd1,
    S_READ     = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [IDX_W-1:0]    issue_idx_q, issue_idx_d;
  logic [IDX_W-1:0]    cap_idx_q, cap_idx_d;
  logic                cap_vld_q, cap_vld_d;
  logic                bus_req_q, bus_req_d;
  logic                if_done_q, if_done_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    mem_a_d     = mem_a_q;
    issue_idx_d = issue_idx_q;
    cap_idx_d   = cap_idx_q;
    cap_vld_d   = cap_vld_q;
    bus_req_d   = bus_req_q;
    if_data_d   = if_data_q;
    if_done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_en && !rollback) begin
          base_d    = if_pc & ~OFF_MASK;
          bus_req_d = 1'b1;
          state_d   = S_WAIT_GNT;
        end
      end

      S_WAIT_GNT: begin
        if (bus_gnt) begin
          issue_idx_d = '0;
          cap_idx_d   = '0;
          cap_vld_d   = 1'b0;
          mem_a_d     = base_q;
          state_d     = S_READ;
        end
      end

      S_READ: begin
        // Address issue runs one cycle ahead of capture; it parks on the
        // last byte while the final read returns.
        if (issue_idx_q != LAST_IDX) begin
          issue_idx_d = issue_idx_q + IDX_W'(1);
        end
        // base is aligned, so the sum never carries out of the line.
        mem_a_d   = base_q + ADDR_W'(issue_idx_d);
        cap_vld_d = 1'b1;
        if (cap_vld_q) begin
          if_data_d[{cap_idx_q, 3'b000} +: 8] = mem_din;
          cap_idx_d = cap_idx_q + IDX_W'(1);
          if (cap_idx_q == LAST_IDX) begin
            bus_req_d = 1'b0;
            mem_a_d   = '0;
            if_done_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Rollback wins over acceptance and over DONE entry.
    if (rollback) begin
      state_d   = S_IDLE;
      bus_req_d = 1'b0;
      mem_a_d   = '0;
      if_done_d = 1'b0;
    end
  end

  // State and datapath registers; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      mem_a_q     <= '0;
      issue_idx_q <= '0;
      cap_idx_q   <= '0;
      cap_vld_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      base_q      <= base_d;
      mem_a_q     <= mem_a_d;
      issue_idx_q <= issue_idx_d;
      cap_idx_q   <= cap_idx_d;
      cap_vld_q   <= cap_vld_d;
      bus_req_q   <= bus_req_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
    end
  end

  assign if_done = if_done_q;
  assign if_data = if_data_q;
  assign bus_req = bus_req_q;
  assign mem_a   = mem_a_q;
  assign mem_wr  = 1'b0;

`ifdef IF_FILL_STAT_EN
  logic [31:0] stat_fills_q, stat_fills_d;
  logic [31:0] stat_aborts_q, stat_aborts_d;

  // Completed fills and rollback-aborted fills; both wrap naturally.
  always_comb begin
    stat_fills_d  = stat_fills_q;
    stat_aborts_d = stat_aborts_q;
    if (state_q == S_READ && state_d == S_DONE) begin
      stat_fills_d = stat_fills_q + 32'd1;
    end
    if (rollback && (state_q == S_WAIT_GNT || state_q == S_READ)) begin
      stat_aborts_d = stat_aborts_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fills_q  <= '0;
      stat_aborts_q <= '0;
    end else if (rdy) begin
      stat_fills_q  <= stat_fills_d;
      stat_aborts_q <= stat_aborts_d;
    end
  end

  assign stat_fills  = stat_fills_q;
  assign stat_aborts = stat_aborts_q;
`endif

endmodule
